if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage of the five-stage pipeline: owns the PC, issues one instruction-memory request at a time and presents the fetched instruction with its PC and PC+4 to the IF/ID pipeline register. It is the producer for IF/ID, driving the `if_now_pc`, `if_pc_plus_4` and `if_instruction` inputs of that register. It handles hazard-unit stalls and EX-stage branch/jump redirects.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP`, default 32'h0000_0013: `if_instruction` value when no valid instruction is present (addi x0,x0,0).
- `sys_clk`, in, 1: clock. All state changes on the rising edge.
- `sys_rst`, in, 1: reset. Asynchronous, active-high.
- `stall`, in, 1: downstream cannot accept. Outputs hold.
- `redirect_en`, in, 1: taken branch or jump from EX.
- `redirect_pc`, in, 32: redirect target.
- `imem_req`, out, 1: request valid.
- `imem_addr`, out, 32: request address, equal to the current PC.
- `imem_ready`, in, 1: memory accepts the request this cycle.
- `imem_rvalid`, in, 1: response data valid.
- `imem_rdata`, in, 32: response instruction.
- `if_now_pc`, out, 32: PC of the presented instruction.
- `if_pc_plus_4`, out, 32: `if_now_pc` + 4.
- `if_instruction`, out, 32: fetched instruction.
- `if_valid`, out, 1: outputs hold a real instruction.

## Operation
- **Acceptance:** an instruction is accepted on any rising edge where `if_valid`=1 and `stall`=0.
- **FETCH state:** `imem_req` = !(`if_valid` && `stall`), with `imem_addr` = `pc`. A request is issued when `imem_req` && `imem_ready`; the state then goes to WAIT. `imem_req` is combinational from state and registered flags only.
- **WAIT state:** one request is outstanding; `imem_req` = 0. On `imem_rvalid`:
  - if `kill` is set, discard the data, clear `kill`, go to FETCH;
  - else, if the slot is free or being accepted this edge, load the outputs (`if_now_pc`=`pc`, `if_pc_plus_4`=`pc`+4, `if_instruction`=`imem_rdata`, `if_valid`=1), set `pc` to `pc`+4, go to FETCH;
  - otherwise capture the response into `buf_instr`/`buf_pc` and go to HOLD.
- **HOLD state:** no request is issued. When the slot is accepted, move the buffer to the outputs, set `pc` to `buf_pc`+4, go to FETCH.
- **Slot drain:** an accepted slot with no new data clears `if_valid` to 0 and sets `if_instruction` to `NOP`.
- **Redirect** has highest priority and overrides `stall`. On an edge with `redirect_en`=1:
  - `pc`<=`redirect_pc`, `if_valid`<=0, `if_instruction`<=`NOP`, buffer discarded;
  - FETCH with a request issued this edge: go to WAIT with `kill`=1;
  - FETCH with no request issued: stay in FETCH; the new address appears next cycle;
  - WAIT without `imem_rvalid`: `kill`<=1;
  - WAIT with `imem_rvalid`: drop the data, go to FETCH;
  - HOLD: go to FETCH.
- **Arithmetic:** PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. There is no alignment check; `redirect_pc` is used as given.
- **Reset** (async, any state, including mid-request): state=FETCH, `pc`=`RESET_PC`, `kill`=0, `if_valid`=0, `if_now_pc`=0, `if_pc_plus_4`=0, `if_instruction`=`NOP`. A response arriving after reset deasserts with no request outstanding is ignored.

## Timing
- The first request appears the first cycle after `sys_rst` falls.
- With zero-wait memory (`imem_ready`=1, `imem_rvalid` one cycle after acceptance), `if_valid` rises on the edge that samples `imem_rvalid`. Steady throughput is one instruction per 2 cycles.
- At most one outstanding request at any time.
- Redirect penalty: the earliest valid target instruction is 2 edges after the redirect edge, plus any kill drain time.
- All outputs except `imem_req`/`imem_addr` are registered.

## Structure
- **Shared `para.v`:**
  - `` `width `` (31:0);
  - `RESET_PC`/`NOP` defaults;
  - FETCH/WAIT/HOLD 2-bit encodings.
- **Sub-module `if_pc_gen`:** the natural split. It holds the `pc` register and the next-PC mux (`RESET_PC`, `redirect_pc`, `pc`+4, `buf_pc`+4, hold).
- **In `if_fetch`:** the FSM, `kill` flag and buffer stay here.

## Test plan
- **Reset and sequential fetch:** release reset, zero-wait memory returning addr^32'hA5A5_0000 → `if_valid` pulses carry PCs 0,4,8 with matching data, and `if_pc_plus_4`=PC+4 each time.
- **Stall during WAIT:** raise `stall` while a response is pending → data goes to HOLD. Outputs hold the old instruction until `stall` falls, then the buffered instruction appears the next edge. Nothing is dropped or duplicated.
- **Redirect in WAIT without rvalid:** `redirect_pc`=32'h100 → the stale response is discarded, next `imem_addr`=32'h100, first valid `if_now_pc`=32'h100.
- **Redirect coincident with `imem_ready` and with `imem_rvalid`:** both cases → no stale instruction is ever presented with `if_valid`=1.
- **Wrap and reset mid-request:** redirect to 32'hFFFF_FFFC → next PC is 0. Assert `sys_rst` while in WAIT → all outputs take reset values immediately, and a late `imem_rvalid` is ignored.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared definitions for the instruction-fetch stage.
//   - WIDTH          : datapath width (address and instruction)
//   - RESET_PC_DEF   : default first fetch address after reset
//   - NOP_DEF        : default bubble instruction (addi x0,x0,0)
//   - fetch_state_t  : FETCH/WAIT/HOLD 2-bit encodings
//   - pc_sel_t       : next-PC mux select for if_pc_gen
//   - pc_inc()       : PC + 4, modulo 2^32
package if_fetch_pkg;

    localparam int WIDTH = 32;

    localparam logic [WIDTH-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [WIDTH-1:0] NOP_DEF      = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_WAIT  = 2'b01,
        S_HOLD  = 2'b10
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'b00,
        PC_REDIRECT = 2'b01,
        PC_INC      = 2'b10,
        PC_BUF_INC  = 2'b11
    } pc_sel_t;

    // Carry out of bit 31 is dropped, so 32'hFFFF_FFFC wraps to 0.
    function automatic logic [WIDTH-1:0] pc_inc(input logic [WIDTH-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory request/response bus.
//   imem_req/imem_addr   : fetch -> memory, request valid and address
//   imem_ready           : memory -> fetch, request accepted this cycle
//   imem_rvalid/rdata    : memory -> fetch, response valid and instruction
// Handshake: a request transfers on a rising edge where imem_req and
// imem_ready are both 1; the response is a single-cycle imem_rvalid pulse
// some later cycle, and at most one request is outstanding at a time.
// modports: master = fetch stage, slave = instruction memory.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ready;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_pc_gen.sv
// if_pc_gen: program-counter register and next-PC mux.
//   i_clk, i_rst    : clock, asynchronous active-high reset (pc <= RESET_PC)
//   i_sel           : next-PC source (hold, redirect, pc+4, buf_pc+4)
//   i_redirect_pc   : redirect target, used as given (no alignment check)
//   i_buf_pc        : PC of the buffered response
//   o_pc            : current PC
module if_pc_gen
    import if_fetch_pkg::*;
#(
    parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  pc_sel_t          i_sel,
    input  logic [WIDTH-1:0] i_redirect_pc,
    input  logic [WIDTH-1:0] i_buf_pc,
    output logic [WIDTH-1:0] o_pc
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        case (i_sel)
            PC_REDIRECT: w_pc_next = i_redirect_pc;
            PC_INC:      w_pc_next = pc_inc(r_pc);
            PC_BUF_INC:  w_pc_next = pc_inc(i_buf_pc);
            default:     w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage, producer for the IF/ID register.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   stall            : IF/ID cannot accept; the presented slot holds
//   redirect_en/pc   : taken branch/jump from EX, overrides stall
//   imem             : instruction-memory bus (master side)
//   if_now_pc, if_pc_plus_4, if_instruction, if_valid : registered slot
//   dbg_state        : current FSM state
// A slot is accepted on any edge where if_valid=1 and stall=0.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [WIDTH-1:0] NOP      = NOP_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             stall,
    input  logic             redirect_en,
    input  logic [WIDTH-1:0] redirect_pc,
    if_fetch_if.master       imem,
    output logic [WIDTH-1:0] if_now_pc,
    output logic [WIDTH-1:0] if_pc_plus_4,
    output logic [WIDTH-1:0] if_instruction,
    output logic             if_valid,
    output fetch_state_t     dbg_state
);

    fetch_state_t     r_state;
    logic             r_kill;
    logic [WIDTH-1:0] r_buf_instr;
    logic [WIDTH-1:0] r_buf_pc;
    logic [WIDTH-1:0] r_now_pc;
    logic [WIDTH-1:0] r_pc_plus_4;
    logic [WIDTH-1:0] r_instr;
    logic             r_valid;

    logic [WIDTH-1:0] w_pc;
    logic             w_accept;
    logic             w_req;
    logic             w_issue;
    logic             w_slot_open;
    logic             w_load;
    pc_sel_t          w_pc_sel;

    assign w_accept    = r_valid && !stall;
    // Never request while a stalled slot is occupied; otherwise fetch
    // whenever idle.
    assign w_req       = (r_state == S_FETCH) && !(r_valid && stall);
    assign w_issue     = w_req && imem.imem_ready;
    assign w_slot_open = !r_valid || w_accept;
    assign w_load      = (r_state == S_WAIT) && imem.imem_rvalid && !r_kill && w_slot_open;

    always_comb begin
        w_pc_sel = PC_HOLD;
        if (redirect_en) begin
            w_pc_sel = PC_REDIRECT;
        end else if (w_load) begin
            w_pc_sel = PC_INC;
        end else if ((r_state == S_HOLD) && w_accept) begin
            w_pc_sel = PC_BUF_INC;
        end
    end

    if_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .i_clk         (sys_clk),
        .i_rst         (sys_rst),
        .i_sel         (w_pc_sel),
        .i_redirect_pc (redirect_pc),
        .i_buf_pc      (r_buf_pc),
        .o_pc          (w_pc)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= S_FETCH;
            r_kill      <= 1'b0;
            r_valid     <= 1'b0;
            r_now_pc    <= '0;
            r_pc_plus_4 <= '0;
            r_instr     <= NOP;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
        end else if (redirect_en) begin
            // Flush the slot; the buffer is simply abandoned by leaving HOLD.
            r_valid <= 1'b0;
            r_instr <= NOP;
            case (r_state)
                S_FETCH: begin
                    // The memory took the old address this edge: its
                    // response must be thrown away when it returns.
                    if (w_issue) begin
                        r_state <= S_WAIT;
                        r_kill  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        r_state <= S_FETCH;
                        r_kill  <= 1'b0;
                    end else begin
                        r_kill <= 1'b1;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end else begin
            // Drain by default; a load below overrides it on the same edge.
            if (w_accept) begin
                r_valid <= 1'b0;
                r_instr <= NOP;
            end
            case (r_state)
                S_FETCH: begin
                    if (w_issue) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        r_state <= S_FETCH;
                        if (r_kill) begin
                            r_kill <= 1'b0;
                        end else if (w_slot_open) begin
                            r_now_pc    <= w_pc;
                            r_pc_plus_4 <= pc_inc(w_pc);
                            r_instr     <= imem.imem_rdata;
                            r_valid     <= 1'b1;
                        end else begin
                            // Slot still occupied: park the response.
                            r_buf_instr <= imem.imem_rdata;
                            r_buf_pc    <= w_pc;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_now_pc    <= r_buf_pc;
                        r_pc_plus_4 <= pc_inc(r_buf_pc);
                        r_instr     <= r_buf_instr;
                        r_valid     <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = w_pc;

    assign if_now_pc      = r_now_pc;
    assign if_pc_plus_4   = r_pc_plus_4;
    assign if_instruction = r_instr;
    assign if_valid       = r_valid;
    assign dbg_state      = r_state;

endmodule
